// File: rtl/result_drain_if.sv
// Valid/ready beat stream carrying one drained accumulator element per beat with its
// coordinates, last-beat flag and saturation flag.
interface result_drain_if #(
  parameter int unsigned OutWidth = 8,
  parameter int unsigned RowW     = 2,
  parameter int unsigned ColW     = 2
) ();
  logic                out_valid;
  logic                out_ready;
  logic [OutWidth-1:0] out_data;
  logic [RowW-1:0]     out_row;
  logic [ColW-1:0]     out_col;
  logic                out_last;
  logic                out_sat;

  modport master (
    output out_valid,
    output out_data,
    output out_row,
    output out_col,
    output out_last,
    output out_sat,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_row,
    input  out_col,
    input  out_last,
    input  out_sat,
    output out_ready
  );
endinterface

// File: rtl/result_drain.sv
// Snapshots every PE accumulator in one cycle, then streams the copy out row-major,
// one element per valid/ready beat, with optional unsigned saturation.
module result_drain #(
  parameter int unsigned ROWS      = 4,
  parameter int unsigned COLS      = 4,
  parameter int unsigned ACC_WIDTH = 16,
  parameter int unsigned OUT_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [ROWS*COLS*ACC_WIDTH-1:0]  c_flat,
  output logic                            busy,
  output logic                            done,
  result_drain_if.master                  out_if
);
  localparam int unsigned RowW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned ColW = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;

  state_e              state_q, state_d;
  logic [RowW-1:0]     row_q, row_d;
  logic [ColW-1:0]     col_q, col_d;
  logic                capture;
  logic                last_beat;
  logic [ACC_WIDTH-1:0] snap_q [ROWS][COLS];
  logic [ACC_WIDTH-1:0] elem;
  logic [OUT_WIDTH-1:0] elem_data;
  logic                elem_sat;

  assign last_beat = (row_q == RowW'(ROWS - 1)) && (col_q == ColW'(COLS - 1));
  assign elem      = snap_q[row_q][col_q];

  if (OUT_WIDTH < ACC_WIDTH) begin : g_sat
    assign elem_sat  = |elem[ACC_WIDTH-1:OUT_WIDTH];
    assign elem_data = elem_sat ? '1 : elem[OUT_WIDTH-1:0];
  end else begin : g_nosat
    assign elem_sat  = 1'b0;
    assign elem_data = elem[OUT_WIDTH-1:0];
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          capture = 1'b1;
          row_d   = '0;
          col_d   = '0;
          state_d = StStream;
        end
      end
      StStream: begin
        if (out_if.out_ready) begin
          if (last_beat) begin
            state_d = StDone;
          end else if (col_q == ColW'(COLS - 1)) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  // Buffer needs no reset: its contents are only observed after a capture.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int r = 0; r < int'(ROWS); r++) begin
        for (int c = 0; c < int'(COLS); c++) begin
          snap_q[r][c] <= c_flat[(r * int'(COLS) + c) * int'(ACC_WIDTH) +: ACC_WIDTH];
        end
      end
    end
  end

  // Beat fields are forced to zero outside STREAM so idle outputs match reset values.
  always_comb begin
    busy             = (state_q == StStream);
    done             = (state_q == StDone);
    out_if.out_valid = busy;
    out_if.out_row   = busy ? row_q : '0;
    out_if.out_col   = busy ? col_q : '0;
    out_if.out_last  = busy & last_beat;
    out_if.out_sat   = busy & elem_sat;
    out_if.out_data  = busy ? elem_data : '0;
  end
endmodule

// File: tb/tb_result_drain.sv
// Directed bench for result_drain: scoreboard of expected beats filled at capture time,
// compared on every handshake, plus hold, latency, done-pulse and reset checks.
module tb_result_drain;
  localparam int unsigned ROWS      = 4;
  localparam int unsigned COLS      = 4;
  localparam int unsigned ACC_WIDTH = 16;
  localparam int unsigned OUT_WIDTH = 8;
  localparam int unsigned N         = ROWS * COLS;

  typedef struct packed {
    logic [OUT_WIDTH-1:0] data;
    logic [1:0]           row;
    logic [1:0]           col;
    logic                 last;
    logic                 sat;
  } beat_t;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     start;
  logic [N*ACC_WIDTH-1:0]   c_flat;
  logic                     busy;
  logic                     done;

  result_drain_if #(.OutWidth(OUT_WIDTH), .RowW(2), .ColW(2)) bus ();

  result_drain #(
    .ROWS      (ROWS),
    .COLS      (COLS),
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .c_flat (c_flat),
    .busy   (busy),
    .done   (done),
    .out_if (bus)
  );

  always #5 clk = ~clk;

  beat_t exp_q[$];
  beat_t held;
  logic  prev_stall = 1'b0;
  int    n_comp = 0;
  int    n_fail = 0;
  int    n_hs   = 0;
  int    n_done = 0;
  int    n_busy = 0;
  int    hs0, d0, b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_comp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t cur_beat();
    beat_t b;
    b.data = bus.out_data;
    b.row  = bus.out_row;
    b.col  = bus.out_col;
    b.last = bus.out_last;
    b.sat  = bus.out_sat;
    return b;
  endfunction

  // Samples outputs (inputs already set for this cycle), then advances one edge.
  task automatic tick();
    beat_t b, e;
    b = cur_beat();
    if (prev_stall) chk("hold", 32'({bus.out_valid, b}), 32'({1'b1, held}));
    if (bus.out_valid && bus.out_ready && !rst) begin
      n_hs++;
      n_comp++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL extra_beat: observed beat %0h expected no beat", b);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("beat_data", 32'(b.data), 32'(e.data));
        chk("beat_row_col_last_sat", 32'({b.row, b.col, b.last, b.sat}),
            32'({e.row, e.col, e.last, e.sat}));
      end
    end
    prev_stall = bus.out_valid && !bus.out_ready && !rst;
    held = b;
    if (done) n_done++;
    if (busy) n_busy++;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int base, input int step);
    for (int i = 0; i < int'(N); i++) c_flat[i*ACC_WIDTH +: ACC_WIDTH] = 16'(base + i * step);
  endtask

  task automatic push_snapshot();
    beat_t e;
    logic [ACC_WIDTH-1:0] v;
    for (int i = 0; i < int'(N); i++) begin
      v      = c_flat[i*ACC_WIDTH +: ACC_WIDTH];
      e.sat  = (v > 16'd255);
      e.data = e.sat ? 8'hFF : v[7:0];
      e.row  = 2'(i / int'(COLS));
      e.col  = 2'(i % int'(COLS));
      e.last = (i == int'(N) - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    push_snapshot();
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit bp);
    int n = 0;
    while (!done && n < budget) begin
      bus.out_ready = bp ? (n % 3 == 0) : 1'b1;
      tick();
      n++;
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  task automatic finish_stream();
    tick();
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    c_flat = '0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_row", 32'(bus.out_row), 32'd0);
    chk("rst_col", 32'(bus.out_col), 32'd0);
    chk("rst_last", 32'(bus.out_last), 32'd0);
    chk("rst_sat", 32'(bus.out_sat), 32'd0);
    chk("rst_data", 32'(bus.out_data), 32'd0);
    rst = 1'b0;
    tick();

    // Basic stream with exact latency and busy/done accounting
    load(100, 1);
    hs0 = n_hs; b0 = n_busy; d0 = n_done;
    do_start();
    chk("first_beat_valid", 32'(bus.out_valid), 32'd1);
    repeat (16) tick();
    chk("done_after_last", 32'(done), 32'd1);
    chk("busy_in_done", 32'(busy), 32'd0);
    chk("valid_in_done", 32'(bus.out_valid), 32'd0);
    finish_stream();
    chk("basic_busy_cycles", 32'(n_busy - b0), 32'd16);
    chk("basic_handshakes", 32'(n_hs - hs0), 32'd16);
    chk("basic_done_pulses", 32'(n_done - d0), 32'd1);

    // Saturation boundaries
    for (int i = 0; i < int'(N); i++) c_flat[i*ACC_WIDTH +: ACC_WIDTH] = 16'(i * 40);
    c_flat[0*ACC_WIDTH +: ACC_WIDTH] = 16'h0000;
    c_flat[1*ACC_WIDTH +: ACC_WIDTH] = 16'h00FF;
    c_flat[2*ACC_WIDTH +: ACC_WIDTH] = 16'h0100;
    c_flat[3*ACC_WIDTH +: ACC_WIDTH] = 16'hFFFF;
    do_start();
    wait_done(100, 1'b0);
    finish_stream();

    // Backpressure 1,0,0 repeating
    load(200, 3);
    hs0 = n_hs;
    do_start();
    wait_done(200, 1'b1);
    chk("bp_handshakes", 32'(n_hs - hs0), 32'd16);
    finish_stream();
    bus.out_ready = 1'b1;

    // Snapshot isolation
    load(10, 7);
    do_start();
    for (int i = 0; i < int'(N); i++) c_flat[i*ACC_WIDTH +: ACC_WIDTH] = 16'hAAAA;
    wait_done(100, 1'b0);
    finish_stream();

    // Start while busy and during done is ignored; start after done captures
    load(50, 1);
    hs0 = n_hs; d0 = n_done;
    do_start();
    for (int i = 0; i < int'(N); i++) begin
      start = (i == 3 || i == 15);
      bus.out_ready = 1'b1;
      tick();
    end
    chk("done_after_busy_starts", 32'(done), 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_in_done_ignored", 32'(bus.out_valid), 32'd0);
    chk("busy_start_handshakes", 32'(n_hs - hs0), 32'd16);
    chk("busy_start_done_pulses", 32'(n_done - d0), 32'd1);
    load(60, 2);
    do_start();
    chk("restart_valid", 32'(bus.out_valid), 32'd1);
    wait_done(100, 1'b0);
    finish_stream();

    // Reset mid-stream after beat 5 is accepted
    load(5, 1);
    do_start();
    repeat (6) tick();
    rst = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    rst = 1'b0;
    chk("midrst_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_row_col", 32'({bus.out_row, bus.out_col}), 32'd0);
    exp_q.delete();
    d0 = n_done;
    repeat (3) tick();
    chk("midrst_no_done", 32'(n_done - d0), 32'd0);
    bus.out_ready = 1'b1;
    load(20, 1);
    do_start();
    chk("post_rst_first_valid", 32'(bus.out_valid), 32'd1);
    chk("post_rst_first_row_col", 32'({bus.out_row, bus.out_col}), 32'd0);
    wait_done(100, 1'b0);
    finish_stream();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_fail);
    $finish;
  end
endmodule
